motor_cmd_sequencer: RTL and testbench
======================================

Name: motor_cmd_sequencer

Overview:
Sits between the balance-loop command source and motor_controller, on the same divided clock as motor_controller. Accepts signed per-motor duty commands over a valid/ready handshake. Drives motorN_sign / motorN_upperlimit with:
- magnitude clamping
- slew-rate ramping
- enforced zero-duty dead time on every direction reversal
- a command watchdog and emergency stop, both forcing the motors to zero

Parameters:
TICK_DIV, 1000, clk cycles per ramp tick (>=2)
STEP, 2, duty units moved per tick (1..MAXDUTY)
MAXDUTY, 100, magnitude clamp (<=127)
DEADTIME_TICKS, 4, ticks held at duty 0 before a sign flip (>=1)
WDOG_TICKS, 250, ticks without an accepted command before trip (>=1)

Ports:
clk  in  1  clock, same clock that feeds motor_controller
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_m1  in  8  signed two's-complement motor 1 duty request
cmd_m2  in  8  signed two's-complement motor 2 duty request
estop  in  1  level-sensitive emergency stop
motor1_sign  out  1  1 = forward (positive command)
motor1_upperlimit  out  7  motor 1 duty magnitude
motor2_sign  out  1  as motor 1
motor2_upperlimit  out  7  as motor 1
busy  out  1  either motor not in HOLD
wdog_tripped  out  1  watchdog expired, sticky until next accepted command

Behaviour:
- All outputs are registered.
- Reset values (asynchronous, active-high):
  - signs = 1; upperlimits = 0
  - targets = +0
  - cmd_ready = 0 while reset is high, 1 from the first edge after release
  - busy = 0, wdog_tripped = 0; tick counter = 0; watchdog counter = 0
  - both FSMs in HOLD
- Tick: counter runs 0..TICK_DIV-1. tick = 1 for exactly one clk when counter == TICK_DIV-1, then the counter wraps to 0.
- Accept: on an edge with cmd_valid & cmd_ready, latch both targets.
  - Target sign = cmd bit 7.
  - Target magnitude = min(|cmd|, MAXDUTY); -128 gives MAXDUTY.
  - A zero command has magnitude 0 and no sign change request.
- cmd_ready = !estop (outside reset).
- Per-motor FSM. Step events occur only on edges with tick = 1. cur = output magnitude. need_flip = target magnitude != 0 and target sign != current sign.
  - HOLD: cur == target magnitude and !need_flip. On a tick with a mismatch, go to RAMP and apply the first step on the same tick.
  - RAMP, !need_flip: cur moves toward the target by min(STEP, |diff|). Go to HOLD when they are equal.
  - RAMP, need_flip: cur decreases by min(STEP, cur). When cur == 0, go to DEAD. If cur is already 0, enter DEAD on this tick.
  - DEAD: cur held at 0. Count DEADTIME_TICKS ticks, then toggle sign and go to RAMP. The first nonzero step comes on the next tick.
- Flip rules:
  - A sign toggles only on DEAD exit.
  - A target of 0 never toggles the sign.
  - A retarget during DEAD does not shorten or abort it. After DEAD exits, the FSM re-evaluates from the new target, which may cause another flip cycle.
- Retarget mid-RAMP: ramping continues from the current cur with no restart.
- Latency: command accepted at edge N. The first output change happens at the first tick edge after N. For a fresh move with no flip, it is never earlier than edge N+1.
- Watchdog:
  - Counts ticks since the last accepted command.
  - When the count reaches WDOG_TICKS: set wdog_tripped, set both targets to 0, and hold the counter. The motors then ramp down normally.
  - An accepted command clears wdog_tripped and the counter.
  - A command accepted on the expiry edge wins: no trip occurs.
- estop high:
  - On the next edge: both upperlimits = 0, targets = 0, FSMs go to HOLD, DEAD counters are cleared, signs are held.
  - Ramping is bypassed.
  - The watchdog counter is held; wdog_tripped is unchanged.
  - After estop falls, outputs stay at 0 until a new command is accepted.
- busy = (FSM1 != HOLD) | (FSM2 != HOLD).
- Reset asserted mid-operation returns everything to the reset values immediately, regardless of FSM state.

Test Plan:
1. TICK_DIV=4, STEP=2: after reset send cmd_m1=+10. Required: motor1_sign stays 1; upperlimit goes 2,4,6,8,10 on successive ticks (every 4 clk); busy drops on the tick that reaches 10.
2. From +10 steady, send cmd_m1=-6 (DEADTIME_TICKS=4). Required: upperlimit 8,6,4,2,0; then 4 ticks at 0 with sign 1; then sign flips to 0 and upperlimit goes 2,4,6.
3. Send cmd_m2=+127, then cmd_m2=-128. Required: +127 ramps to and holds 100. -128 ramps down to 0, holds DEAD, flips sign to 0, and ramps to 100. The upperlimit never exceeds 100.
4. WDOG_TICKS=8, hold +20 with no new commands. Required: wdog_tripped=1 at the 8th tick; upperlimit ramps 18,16,...,0; the next accepted command clears wdog_tripped.
5. Raise estop mid-ramp at upperlimit 12. Required: both upperlimits are 0 on the next edge and cmd_ready=0. After estop drops, outputs stay at 0 until cmd_m1=+4 is accepted, then ramp 2,4.
6. Assert reset mid-DEAD. Required: immediate signs=1, upperlimits=0, busy=0, cmd_ready=0. After release, cmd_ready=1 on the next edge.

Source files
------------

// File: rtl/motor_cmd_sequencer.sv
// Signed duty-command sequencer for two motors: clamps, slew-limits and inserts
// zero-duty dead time on every direction reversal, with watchdog and estop.
module motor_cmd_sequencer #(
  parameter int TICK_DIV       = 1000,
  parameter int STEP           = 2,
  parameter int MAXDUTY        = 100,
  parameter int DEADTIME_TICKS = 4,
  parameter int WDOG_TICKS     = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_m1,
  input  logic [7:0] cmd_m2,
  input  logic       estop,
  output logic       motor1_sign,
  output logic [6:0] motor1_upperlimit,
  output logic       motor2_sign,
  output logic [6:0] motor2_upperlimit,
  output logic       busy,
  output logic       wdog_tripped
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int WW = $clog2(WDOG_TICKS + 1);
  localparam int DW = $clog2(DEADTIME_TICKS + 1);
  localparam logic [6:0] STEP_C = 7'(STEP);
  localparam logic [6:0] MAX_C  = 7'(MAXDUTY);

  typedef enum logic [1:0] {HOLD, RAMP, DEAD} state_t;

  function automatic logic [6:0] min7(input logic [6:0] a, input logic [6:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [TW-1:0]   tick_cnt_reg;
  logic            tick;
  logic            cmd_ready_reg;
  logic            accept;
  logic [WW-1:0]   wdog_cnt_reg;
  logic            wdog_tripped_reg;
  logic            wdog_expire;
  logic            busy_reg;
  logic [1:0][7:0] cmd_vec;
  logic [1:0]      sign_vec;
  logic [1:0]      busy_next_vec;
  logic [1:0][6:0] cur_vec;

  assign tick        = (tick_cnt_reg == TW'(TICK_DIV - 1));
  // estop overrides a command landing on the same edge
  assign accept      = cmd_valid & cmd_ready_reg & ~estop;
  assign wdog_expire = tick & ~accept & ~estop & (wdog_cnt_reg == WW'(WDOG_TICKS - 1));
  assign cmd_vec     = {cmd_m2, cmd_m1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_reg     <= '0;
      cmd_ready_reg    <= 1'b0;
      wdog_cnt_reg     <= '0;
      wdog_tripped_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      tick_cnt_reg  <= tick ? '0 : tick_cnt_reg + TW'(1);
      cmd_ready_reg <= ~estop;
      busy_reg      <= |busy_next_vec;
      if (!estop) begin
        if (accept) begin
          wdog_cnt_reg     <= '0;
          wdog_tripped_reg <= 1'b0;
        end else if (tick && wdog_cnt_reg != WW'(WDOG_TICKS)) begin
          wdog_cnt_reg <= wdog_cnt_reg + WW'(1);
          if (wdog_expire) wdog_tripped_reg <= 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_motor
      state_t        state_reg, state_next;
      logic          sign_reg, sign_next;
      logic          tgt_sign_reg, tgt_sign_next;
      logic [6:0]    cur_reg, cur_next;
      logic [6:0]    tgt_mag_reg, tgt_mag_next;
      logic [6:0]    toward, flip_dec, cmd_mag;
      logic [7:0]    cmd_abs;
      logic [DW-1:0] dead_reg, dead_next;
      logic          need_flip;

      // -128 maps to 8'h80 = 128 unsigned, which then clamps to MAXDUTY
      assign cmd_abs   = cmd_vec[gi][7] ? (~cmd_vec[gi] + 8'd1) : cmd_vec[gi];
      assign cmd_mag   = (cmd_abs > {1'b0, MAX_C}) ? MAX_C : cmd_abs[6:0];
      assign need_flip = (tgt_mag_reg != 7'd0) && (tgt_sign_reg != sign_reg);
      assign flip_dec  = cur_reg - min7(STEP_C, cur_reg);
      assign toward    = (tgt_mag_reg > cur_reg)
                       ? cur_reg + min7(STEP_C, tgt_mag_reg - cur_reg)
                       : cur_reg - min7(STEP_C, cur_reg - tgt_mag_reg);

      always_comb begin
        state_next    = state_reg;
        cur_next      = cur_reg;
        sign_next     = sign_reg;
        dead_next     = dead_reg;
        tgt_sign_next = tgt_sign_reg;
        tgt_mag_next  = tgt_mag_reg;
        if (estop) begin
          state_next   = HOLD;
          cur_next     = 7'd0;
          dead_next    = '0;
          tgt_mag_next = 7'd0;
        end else begin
          if (tick) begin
            case (state_reg)
              HOLD, RAMP: begin
                if (need_flip) begin
                  cur_next   = flip_dec;
                  state_next = (flip_dec == 7'd0) ? DEAD : RAMP;
                  dead_next  = '0;
                end else if (cur_reg != tgt_mag_reg) begin
                  cur_next   = toward;
                  state_next = (toward == tgt_mag_reg) ? HOLD : RAMP;
                end else begin
                  state_next = HOLD;
                end
              end
              DEAD: begin
                if (dead_reg == DW'(DEADTIME_TICKS - 1)) begin
                  sign_next  = ~sign_reg;
                  state_next = RAMP;
                  dead_next  = '0;
                end else begin
                  dead_next = dead_reg + DW'(1);
                end
              end
              default: state_next = HOLD;
            endcase
          end
          if (accept) begin
            // sign encodes forward = 1, so a non-negative command targets sign 1
            tgt_sign_next = ~cmd_vec[gi][7];
            tgt_mag_next  = cmd_mag;
          end else if (wdog_expire) begin
            tgt_mag_next = 7'd0;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg    <= HOLD;
          cur_reg      <= 7'd0;
          sign_reg     <= 1'b1;
          dead_reg     <= '0;
          tgt_sign_reg <= 1'b1;
          tgt_mag_reg  <= 7'd0;
        end else begin
          state_reg    <= state_next;
          cur_reg      <= cur_next;
          sign_reg     <= sign_next;
          dead_reg     <= dead_next;
          tgt_sign_reg <= tgt_sign_next;
          tgt_mag_reg  <= tgt_mag_next;
        end
      end

      assign sign_vec[gi]      = sign_reg;
      assign cur_vec[gi]       = cur_reg;
      assign busy_next_vec[gi] = (state_next != HOLD);
    end
  endgenerate

  assign cmd_ready         = cmd_ready_reg;
  assign motor1_sign       = sign_vec[0];
  assign motor1_upperlimit = cur_vec[0];
  assign motor2_sign       = sign_vec[1];
  assign motor2_upperlimit = cur_vec[1];
  assign busy              = busy_reg;
  assign wdog_tripped      = wdog_tripped_reg;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer: ramp, reversal dead time, clamp,
// estop, reset mid-DEAD and watchdog, with hand-computed expectations.
module tb_motor_cmd_sequencer;
  localparam int TICK_DIV = 4;
  localparam int STEP     = 2;
  localparam int MAXDUTY  = 100;
  localparam int DEADT    = 4;
  localparam int WDOG     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_m1 = 8'd0;
  logic [7:0] cmd_m2 = 8'd0;
  logic       estop = 1'b0;
  logic       motor1_sign, motor2_sign;
  logic [6:0] motor1_upperlimit, motor2_upperlimit;
  logic       busy, wdog_tripped;

  int checks = 0;
  int errors = 0;
  int tcnt;

  motor_cmd_sequencer #(
    .TICK_DIV(TICK_DIV), .STEP(STEP), .MAXDUTY(MAXDUTY),
    .DEADTIME_TICKS(DEADT), .WDOG_TICKS(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_m1(cmd_m1), .cmd_m2(cmd_m2), .estop(estop),
    .motor1_sign(motor1_sign), .motor1_upperlimit(motor1_upperlimit),
    .motor2_sign(motor2_sign), .motor2_upperlimit(motor2_upperlimit),
    .busy(busy), .wdog_tripped(wdog_tripped)
  );

  always #5 clk = ~clk;

  // Reference divider: after a tick edge this reads 0
  always @(posedge clk or posedge reset) begin
    if (reset) tcnt <= 0;
    else       tcnt <= (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_step();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (tcnt != 0 && n <= TICK_DIV);
  endtask

  task automatic send(input int m1, input int m2);
    check("send_ready", cmd_ready, 1);
    cmd_m1 = 8'(m1);
    cmd_m2 = 8'(m2);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("cmd m1=%0d m2=%0d t=%0t", m1, m2, $time);
  endtask

  initial begin
    int exp_ul2, exp_s2;
    int t2_ul [12] = '{8, 6, 4, 2, 0, 0, 0, 0, 0, 2, 4, 6};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sign1", motor1_sign, 1);
    check("rst_ul1", motor1_upperlimit, 0);
    check("rst_sign2", motor2_sign, 1);
    check("rst_ul2", motor2_upperlimit, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_wdog", wdog_tripped, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("rel_ready", cmd_ready, 1);
    tick_step();

    // Plain ramp 0 -> +10
    send(10, 0);
    for (int i = 1; i <= 5; i++) begin
      tick_step();
      check($sformatf("t1_ul1[%0d]", i), motor1_upperlimit, 2 * i);
      check($sformatf("t1_s1[%0d]", i), motor1_sign, 1);
      check($sformatf("t1_busy[%0d]", i), busy, (i < 5) ? 1 : 0);
    end

    // estop mid-ramp at 12
    send(20, 0);
    tick_step();
    check("t5_ul1_pre", motor1_upperlimit, 12);
    check("t5_busy_pre", busy, 1);
    estop = 1'b1;
    @(posedge clk); #1;
    check("t5_ul1", motor1_upperlimit, 0);
    check("t5_ul2", motor2_upperlimit, 0);
    check("t5_ready", cmd_ready, 0);
    check("t5_s1", motor1_sign, 1);
    check("t5_busy", busy, 0);
    cmd_m1 = 8'd50;
    cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_hold_ul1", motor1_upperlimit, 0);
    check("t5_hold_ready", cmd_ready, 0);
    check("t5_hold_wdog", wdog_tripped, 0);
    estop = 1'b0;
    cmd_valid = 1'b0;
    tick_step();
    check("t5_post_ready", cmd_ready, 1);
    check("t5_post_ul1", motor1_upperlimit, 0);
    check("t5_post_busy", busy, 0);
    tick_step();
    check("t5_post2_ul1", motor1_upperlimit, 0);
    send(4, 0);
    tick_step();
    check("t5_r_ul1a", motor1_upperlimit, 2);
    tick_step();
    check("t5_r_ul1b", motor1_upperlimit, 4);
    check("t5_r_busy", busy, 0);
    send(10, 0);
    for (int i = 1; i <= 3; i++) begin
      tick_step();
      check($sformatf("t5_to10[%0d]", i), motor1_upperlimit, 4 + 2 * i);
    end

    // Reversal +10 -> -6 with dead time
    send(-6, 0);
    for (int i = 1; i <= 12; i++) begin
      tick_step();
      check($sformatf("t2_ul1[%0d]", i), motor1_upperlimit, t2_ul[i-1]);
      check($sformatf("t2_s1[%0d]", i), motor1_sign, (i <= 8) ? 1 : 0);
      check($sformatf("t2_busy[%0d]", i), busy, (i < 12) ? 1 : 0);
      if (i == 4 || i == 8) send(-6, 0);
    end

    // Clamp: +127 -> 100, then -128 -> reversal to 100
    send(-6, 127);
    for (int i = 1; i <= 52; i++) begin
      tick_step();
      exp_ul2 = (i < 50) ? 2 * i : 100;
      check($sformatf("t3u_ul2[%0d]", i), motor2_upperlimit, exp_ul2);
      check($sformatf("t3u_s2[%0d]", i), motor2_sign, 1);
      check($sformatf("t3u_ul1[%0d]", i), motor1_upperlimit, 6);
      check($sformatf("t3u_busy[%0d]", i), busy, (i < 50) ? 1 : 0);
      if (i % 4 == 0) send(-6, 127);
    end
    send(-6, -128);
    for (int j = 1; j <= 104; j++) begin
      tick_step();
      if (j <= 50)      exp_ul2 = 100 - 2 * j;
      else if (j <= 54) exp_ul2 = 0;
      else              exp_ul2 = 2 * (j - 54);
      exp_s2 = (j <= 53) ? 1 : 0;
      check($sformatf("t3d_ul2[%0d]", j), motor2_upperlimit, exp_ul2);
      check($sformatf("t3d_s2[%0d]", j), motor2_sign, exp_s2);
      check($sformatf("t3d_le100[%0d]", j), (motor2_upperlimit <= 7'd100) ? 1 : 0, 1);
      check($sformatf("t3d_busy[%0d]", j), busy, (j < 104) ? 1 : 0);
      if (j % 4 == 0) send(-6, -128);
    end

    // Reset asserted mid-DEAD
    send(6, -100);
    for (int i = 1; i <= 4; i++) begin
      tick_step();
      check($sformatf("t6_ul1[%0d]", i), motor1_upperlimit, (i < 3) ? 6 - 2 * i : 0);
      check($sformatf("t6_s1[%0d]", i), motor1_sign, 0);
      check($sformatf("t6_busy[%0d]", i), busy, 1);
    end
    check("t6_ul2_pre", motor2_upperlimit, 100);
    reset = 1'b1;
    #1;
    check("t6_rst_s1", motor1_sign, 1);
    check("t6_rst_s2", motor2_sign, 1);
    check("t6_rst_ul1", motor1_upperlimit, 0);
    check("t6_rst_ul2", motor2_upperlimit, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_rst_ready2", cmd_ready, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("t6_rel_ready", cmd_ready, 1);
    tick_step();

    // Watchdog: hold +20, trip after 8 quiet ticks, ramp to 0
    send(20, 0);
    for (int i = 1; i <= 10; i++) begin
      tick_step();
      check($sformatf("t4_up_ul1[%0d]", i), motor1_upperlimit, 2 * i);
      if (i == 4 || i == 8) send(20, 0);
    end
    send(20, 0);
    for (int s = 1; s <= 18; s++) begin
      tick_step();
      check($sformatf("t4_ul1[%0d]", s), motor1_upperlimit, (s <= 8) ? 20 : 20 - 2 * (s - 8));
      check($sformatf("t4_wdog[%0d]", s), wdog_tripped, (s >= 8) ? 1 : 0);
      check($sformatf("t4_busy[%0d]", s), busy, (s >= 9 && s < 18) ? 1 : 0);
    end
    tick_step();
    check("t4_still_tripped", wdog_tripped, 1);
    send(0, 0);
    check("t4_clear_wdog", wdog_tripped, 0);
    check("t4_clear_ul1", motor1_upperlimit, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
